// File: rtl/grid_scanout.sv
// grid_scanout: paints a cell grid (one bit per cell) onto a video timing stream, 2-cycle latency.
// Optional macro GRID_SCANOUT_GRIDLINES_EN draws 24'h404040 on the first column/line of each cell.
module grid_scanout #(
    parameter int          GRID_ROWS    = 30,
    parameter int          GRID_COLS    = 40,
    parameter int          CELL_W       = 8,
    parameter int          CELL_H       = 8,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] BORDER_COLOR = 24'h202020
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
    input  logic                           vid_vs_in,
    input  logic                           vid_hs_in,
    input  logic                           vid_de_in,
    output logic                           vid_vs,
    output logic                           vid_hs,
    output logic                           vid_de,
    output logic [23:0]                    vid_rgb
);

    localparam int N_CELLS = GRID_ROWS * GRID_COLS;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int PX_W    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int PY_W    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    // Cell counters need one extra code: the saturated "outside the grid" value.
    localparam int CX_W    = $clog2(GRID_COLS + 1);
    localparam int CY_W    = $clog2(GRID_ROWS + 1);
`ifdef GRID_SCANOUT_GRIDLINES_EN
    localparam logic [23:0] GRIDLINE_COLOR = 24'h404040;
`endif

    logic [PX_W-1:0]  r_px;
    logic [CX_W-1:0]  r_cx;
    logic [PY_W-1:0]  r_py;
    logic [CY_W-1:0]  r_cy;
    logic             r_line_active;
    logic             r_de_prev;

    logic             w_in_grid;
    logic [IDX_W-1:0] w_idx;
    logic             w_cell_bit;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_in_grid  = (r_cx < CX_W'(GRID_COLS)) && (r_cy < CY_W'(GRID_ROWS));
        w_idx      = '0;
        w_cell_bit = 1'b0;
        if (w_in_grid) begin
            w_idx      = IDX_W'(r_cy) * IDX_W'(GRID_COLS) + IDX_W'(r_cx);
            w_cell_bit = grid_ram[w_idx];
        end
    end

    // Position counters: vsync beats hsync beats data enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px          <= '0;
            r_cx          <= '0;
            r_py          <= '0;
            r_cy          <= '0;
            r_line_active <= 1'b0;
            r_de_prev     <= 1'b0;
        end else begin
            r_de_prev <= vid_de_in;
            if (vid_vs_in) begin
                r_px          <= '0;
                r_cx          <= '0;
                r_py          <= '0;
                r_cy          <= '0;
                r_line_active <= 1'b0;
            end else if (vid_hs_in) begin
                r_px <= '0;
                r_cx <= '0;
                if (r_line_active) begin
                    r_line_active <= 1'b0;
                    if (r_py == PY_W'(CELL_H - 1)) begin
                        r_py <= '0;
                        if (r_cy != CY_W'(GRID_ROWS)) r_cy <= r_cy + CY_W'(1);
                    end else begin
                        r_py <= r_py + PY_W'(1);
                    end
                end
            end else if (vid_de_in) begin
                if (!r_de_prev) r_line_active <= 1'b1;
                if (r_px == PX_W'(CELL_W - 1)) begin
                    r_px <= '0;
                    if (r_cx != CX_W'(GRID_COLS)) r_cx <= r_cx + CX_W'(1);
                end else begin
                    r_px <= r_px + PX_W'(1);
                end
            end
        end
    end

    logic r_s1_in_grid, r_s1_bit, r_s1_de, r_s1_hs, r_s1_vs;
`ifdef GRID_SCANOUT_GRIDLINES_EN
    logic r_s1_gridline;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_in_grid  <= 1'b0;
            r_s1_bit      <= 1'b0;
            r_s1_de       <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
`ifdef GRID_SCANOUT_GRIDLINES_EN
            r_s1_gridline <= 1'b0;
`endif
        end else begin
            r_s1_in_grid  <= w_in_grid;
            r_s1_bit      <= w_cell_bit;
            r_s1_de       <= vid_de_in;
            r_s1_hs       <= vid_hs_in;
            r_s1_vs       <= vid_vs_in;
`ifdef GRID_SCANOUT_GRIDLINES_EN
            r_s1_gridline <= (r_px == '0) || (r_py == '0);
`endif
        end
    end

    logic [23:0] w_color;

    always_comb begin
        w_color = BORDER_COLOR;
        if (!r_s1_in_grid) begin
            w_color = BORDER_COLOR;
`ifdef GRID_SCANOUT_GRIDLINES_EN
        end else if (r_s1_gridline) begin
            w_color = GRIDLINE_COLOR;
`endif
        end else if (r_s1_bit) begin
            w_color = FG_COLOR;
        end else begin
            w_color = BG_COLOR;
        end
    end

    // Stage 2: outputs are registered so sync and colour leave on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_vs  <= 1'b0;
            vid_hs  <= 1'b0;
            vid_de  <= 1'b0;
            vid_rgb <= '0;
        end else begin
            vid_vs  <= r_s1_vs;
            vid_hs  <= r_s1_hs;
            vid_de  <= r_s1_de;
            vid_rgb <= r_s1_de ? w_color : '0;
        end
    end

endmodule

// File: tb/tb_grid_scanout.sv
// tb_grid_scanout: drives video timing into grid_scanout and compares each pixel
// against a coordinate-based colour model (x/CELL_W, y/CELL_H lookup).
`timescale 1ns/1ps
module tb_grid_scanout;

    localparam int ROWS = 30, COLS = 40, CW = 8, CH = 8;
    localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h000000, BORDER = 24'h202020;
    localparam logic [23:0] GRIDC = 24'h404040;
    localparam int MAXY = 260, MAXX = 340;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [ROWS*COLS-1:0] grid_ram;
    logic                 vid_vs_in, vid_hs_in, vid_de_in;
    logic                 vid_vs, vid_hs, vid_de;
    logic [23:0]          vid_rgb;

    int checks   = 0;
    int failures = 0;

    grid_scanout dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .grid_ram  (grid_ram),
        .vid_vs_in (vid_vs_in),
        .vid_hs_in (vid_hs_in),
        .vid_de_in (vid_de_in),
        .vid_vs    (vid_vs),
        .vid_hs    (vid_hs),
        .vid_de    (vid_de),
        .vid_rgb   (vid_rgb)
    );

    always #5 clk = ~clk;

    // Record of the previous cycle's inputs; outputs visible after a tick belong to it.
    logic        p_vs, p_hs, p_de, p_tag;
    int          p_x, p_y;
    logic [23:0] p_exp;
    logic        exp_vs, exp_hs, exp_de;
    logic [23:0] exp_rgb;

    logic [23:0] cap_act  [0:MAXY-1][0:MAXX-1];
    logic [23:0] cap_exp  [0:MAXY-1][0:MAXX-1];
    bit          cap_seen [0:MAXY-1][0:MAXX-1];

    function automatic logic [23:0] model_rgb(input int x, input int y);
        int cx, cy;
        cx = x / CW;
        cy = y / CH;
        if (cx >= COLS || cy >= ROWS) return BORDER;
`ifdef GRID_SCANOUT_GRIDLINES_EN
        if ((x % CW) == 0 || (y % CH) == 0) return GRIDC;
`endif
        return grid_ram[cy*COLS + cx] ? FG : BG;
    endfunction

    task automatic clear_record();
        p_vs = 0; p_hs = 0; p_de = 0; p_tag = 0; p_x = 0; p_y = 0; p_exp = '0;
    endtask

    task automatic clear_cap();
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++) begin
                cap_seen[yy][xx] = 0;
                cap_act[yy][xx]  = 'x;
                cap_exp[yy][xx]  = '0;
            end
    endtask

    // One pixel clock. The expected colour uses grid_ram as it is while the pixel is presented.
    task automatic tick(input logic vs, input logic hs, input logic de,
                        input logic tag, input int x, input int y);
        logic [23:0] e;
        e = (tag && de) ? model_rgb(x, y) : 24'h0;
        vid_vs_in = vs;
        vid_hs_in = hs;
        vid_de_in = de;
        @(posedge clk);
        #1;
        exp_vs  = p_vs;
        exp_hs  = p_hs;
        exp_de  = p_de;
        exp_rgb = p_exp;
        if (p_tag) begin
            // A pixel whose delayed enable is missing is recorded as unknown.
            cap_act[p_y][p_x]  = (vid_de === 1'b1) ? vid_rgb : 'x;
            cap_exp[p_y][p_x]  = p_exp;
            cap_seen[p_y][p_x] = 1;
        end
        p_vs = vs; p_hs = hs; p_de = de; p_tag = tag && de; p_x = x; p_y = y; p_exp = e;
    endtask

    task automatic start_frame();
        tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic send_line(input int y, input int npix, input int nblank);
        tick(0, 1, 0, 0, 0, 0);
        repeat (nblank) tick(0, 0, 0, 0, 0, 0);
        for (int x = 0; x < npix; x++) tick(0, 0, 1, 1, x, y);
    endtask

    task automatic flush();
        repeat (3) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < ROWS*COLS; i++) grid_ram[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        int bad, bx, by;
        reset_n = 0;
        randomize_ram();
        clear_record();
        for (int i = 0; i < 6; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
            checks++;
            if ({vid_vs, vid_hs, vid_de, vid_rgb} !== 27'h0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got vs=%b hs=%b de=%b rgb=%h exp all 0",
                         i, vid_vs, vid_hs, vid_de, vid_rgb);
            end
        end
        vid_vs_in = 0; vid_hs_in = 0; vid_de_in = 0;
        reset_n = 1;
        clear_record();
        clear_cap();
        // Without a vsync the counters start from zero, so this line is row 0.
        send_line(0, 16, 1);
        flush();
        start_frame();
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 320; x++) begin
            tick(0, 0, 1, 1, x, 0);
            if (x == 0) begin
                checks++;
                if (vid_de !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_de_latency1 got vid_de=%b exp 0", vid_de);
                end
            end else if (x == 1) begin
                checks++;
                if (vid_de !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_de_latency2 got vid_de=%b exp 1", vid_de);
                end
            end
        end
        flush();
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_line %0d pixels differ, first (%0d,%0d) got %h exp %h",
                     bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
        end
    endtask

    task automatic test_chessboard();
        int bad, bx, by;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) grid_ram[r*COLS + c] = 1'((r + c) % 2);
        clear_cap();
        start_frame();
        for (int y = 0; y < 240; y++)
            send_line(y, ((y % 8) == 0 || y >= 232) ? 320 : 17, 1);
        flush();
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL chess_frame %0d pixels differ, first (%0d,%0d) got %h exp %h",
                     bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
        end
`ifndef GRID_SCANOUT_GRIDLINES_EN
        checks++;
        if (cap_act[0][0] !== 24'h000000) begin
            failures++; $display("FAIL chess_0_0 got %h exp 000000", cap_act[0][0]);
        end
        checks++;
        if (cap_act[0][8] !== 24'hFFFFFF) begin
            failures++; $display("FAIL chess_8_0 got %h exp FFFFFF", cap_act[0][8]);
        end
        checks++;
        if (cap_act[8][8] !== 24'h000000) begin
            failures++; $display("FAIL chess_8_8 got %h exp 000000", cap_act[8][8]);
        end
`endif
        checks++;
        if (cap_act[239][319] !== 24'h000000) begin
            failures++; $display("FAIL chess_319_239 got %h exp 000000", cap_act[239][319]);
        end
    endtask

    task automatic test_overscan();
        int bad, bx, by;
        randomize_ram();
        clear_cap();
        start_frame();
        for (int y = 0; y < 250; y++)
            send_line(y, ((y % 16) == 0 || y >= 240) ? 330 : 4, 1);
        flush();
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < 250; yy++)
            for (int xx = 320; xx < 330; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== BORDER) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0 || !cap_seen[0][329]) begin
            failures++;
            $display("FAIL overscan_cols %0d pixels, first (%0d,%0d) got %h exp 202020",
                     bad, bx, by, cap_act[by][bx]);
        end
        bad = 0; bx = 0; by = 240;
        for (int yy = 240; yy < 250; yy++)
            for (int xx = 0; xx < 330; xx++)
                if (cap_act[yy][xx] !== BORDER) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL overscan_lines %0d pixels, first (%0d,%0d) got %h exp 202020",
                     bad, bx, by, cap_act[by][bx]);
        end
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL overscan_frame %0d pixels differ, first (%0d,%0d) got %h exp %h",
                     bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
        end
    endtask

    task automatic test_midframe_vs();
        int bad, bx, by;
        randomize_ram();
        clear_cap();
        start_frame();
        for (int y = 0; y < 100; y++) send_line(y, 9, 1);
        start_frame();
        send_line(0, 320, 2);
        flush();
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midvs_frame %0d pixels differ, first (%0d,%0d) got %h exp %h",
                     bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
        end
`ifndef GRID_SCANOUT_GRIDLINES_EN
        bad = 0; bx = 0;
        for (int c = 0; c < COLS; c++)
            if (cap_act[0][c*CW + 4] !== (grid_ram[c] ? FG : BG)) begin
                if (bad == 0) bx = c;
                bad++;
            end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midvs_row0 %0d cells, first col %0d got %h exp %h",
                     bad, bx, cap_act[0][bx*CW + 4], grid_ram[bx] ? FG : BG);
        end
`endif
    endtask

    task automatic test_live_update();
        int bad, bx, by;
        grid_ram = '0;
        clear_cap();
        start_frame();
        for (int y = 0; y < 8; y++) send_line(y, 4, 1);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 32; x++) begin
            if (x == 10) grid_ram[41] = 1'b1;
            tick(0, 0, 1, 1, x, 8);
        end
        flush();
        bad = 0; bx = 0; by = 0;
        for (int yy = 0; yy < MAXY; yy++)
            for (int xx = 0; xx < MAXX; xx++)
                if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                    if (bad == 0) begin bx = xx; by = yy; end
                    bad++;
                end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL live_frame %0d pixels differ, first (%0d,%0d) got %h exp %h",
                     bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
        end
`ifndef GRID_SCANOUT_GRIDLINES_EN
        checks++;
        if (cap_act[8][9] !== BG) begin
            failures++; $display("FAIL live_before got %h exp %h", cap_act[8][9], BG);
        end
        bad = 0;
        for (int xx = 10; xx < 16; xx++) if (cap_act[8][xx] !== FG) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL live_after %0d pixels, x=10 got %h exp %h", bad, cap_act[8][10], FG);
        end
        checks++;
        if (cap_act[8][16] !== BG) begin
            failures++; $display("FAIL live_next_cell got %h exp %h", cap_act[8][16], BG);
        end
`endif
    endtask

    task automatic test_gridlines();
        int bad;
        grid_ram = '1;
        clear_cap();
        start_frame();
        for (int y = 0; y < 10; y++) send_line(y, 24, 1);
        flush();
`ifdef GRID_SCANOUT_GRIDLINES_EN
        bad = 0;
        for (int yy = 0; yy < 10; yy++)
            for (int k = 0; k < 3; k++)
                if (cap_act[yy][k*8] !== GRIDC) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL grid_cols %0d pixels, (0,1) got %h exp 404040", bad, cap_act[1][0]);
        end
        bad = 0;
        for (int xx = 0; xx < 24; xx++) if (cap_act[0][xx] !== GRIDC) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL grid_line0 %0d pixels, (1,0) got %h exp 404040", bad, cap_act[0][1]);
        end
`else
        bad = 0;
        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 24; xx++) if (cap_act[yy][xx] !== FG) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL nogrid_allfg %0d pixels, (0,0) got %h exp FFFFFF", bad, cap_act[0][0]);
        end
`endif
        checks++;
        if (cap_act[1][1] !== FG) begin
            failures++; $display("FAIL grid_1_1 got %h exp FFFFFF", cap_act[1][1]);
        end
    endtask

    task automatic test_random_frames();
        int bad, bx, by, y, nlines, npix;
        for (int f = 0; f < 3; f++) begin
            randomize_ram();
            clear_cap();
            start_frame();
            y = 0;
            nlines = $urandom_range(20, 40);
            for (int l = 0; l < nlines; l++) begin
                npix = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 340);
                send_line(y, npix, $urandom_range(1, 4));
                if (npix > 0) y++;
            end
            flush();
            bad = 0; bx = 0; by = 0;
            for (int yy = 0; yy < MAXY; yy++)
                for (int xx = 0; xx < MAXX; xx++)
                    if (cap_seen[yy][xx] && cap_act[yy][xx] !== cap_exp[yy][xx]) begin
                        if (bad == 0) begin bx = xx; by = yy; end
                        bad++;
                    end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_frame%0d %0d pixels differ, first (%0d,%0d) got %h exp %h",
                         f, bad, bx, by, cap_act[by][bx], cap_exp[by][bx]);
            end
        end
    endtask

    task automatic test_sync_align();
        randomize_ram();
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 0, 0, 0);
            checks++;
            if ({vid_vs, vid_hs, vid_de} !== {exp_vs, exp_hs, exp_de}) begin
                failures++;
                $display("FAIL sync_align cycle %0d got vs/hs/de=%b%b%b exp %b%b%b",
                         i, vid_vs, vid_hs, vid_de, exp_vs, exp_hs, exp_de);
            end
            if (!exp_de) begin
                checks++;
                if (vid_rgb !== 24'h0) begin
                    failures++;
                    $display("FAIL blank_rgb cycle %0d got %h exp 000000", i, vid_rgb);
                end
            end
        end
        flush();
    endtask

    task automatic test_reset_midline();
        grid_ram = '1;
        start_frame();
        send_line(0, 6, 1);
        checks++;
        if (vid_de !== 1'b1 || vid_rgb !== exp_rgb) begin
            failures++;
            $display("FAIL midline_pre got de=%b rgb=%h exp de=1 rgb=%h", vid_de, vid_rgb, exp_rgb);
        end
        #3 reset_n = 0;
        #1;
        checks++;
        if ({vid_vs, vid_hs, vid_de, vid_rgb} !== 27'h0) begin
            failures++;
            $display("FAIL midline_reset got vs=%b hs=%b de=%b rgb=%h exp all 0",
                     vid_vs, vid_hs, vid_de, vid_rgb);
        end
        clear_record();
        repeat (2) tick(0, 0, 0, 0, 0, 0);
        reset_n = 1;
        clear_record();
        flush();
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 0;
        grid_ram  = '0;
        vid_vs_in = 0;
        vid_hs_in = 0;
        vid_de_in = 0;
        clear_record();
        test_reset();
        test_chessboard();
        test_overscan();
        test_midframe_vs();
        test_live_update();
        test_gridlines();
        test_random_frames();
        test_sync_align();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grid_scanout.md
GRID_SCANOUT -- requirements
Module: grid_scanout

Interface
REQ-001 The block SHALL provide parameter GRID_ROWS, default 30, number of cell rows in the grid.
REQ-002 The block SHALL provide parameter GRID_COLS, default 40, number of cell columns in the grid.
REQ-003 The block SHALL provide parameter CELL_W, default 8, pixels per cell horizontally.
REQ-004 The block SHALL provide parameter CELL_H, default 8, lines per cell vertically.
REQ-005 The block SHALL provide parameter FG_COLOR, default 24'hFFFFFF, RGB for a cell bit of 1.
REQ-006 The block SHALL provide parameter BG_COLOR, default 24'h000000, RGB for a cell bit of 0.
REQ-007 The block SHALL provide parameter BORDER_COLOR, default 24'h202020, RGB for active pixels outside the grid.
REQ-008 The block SHALL provide port clk, input, 1 bit, the pixel clock; this is the single clock and all logic SHALL be synchronous to its rising edge.
REQ-009 The block SHALL provide port reset_n, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-010 The block SHALL provide port grid_ram, input, GRID_ROWS*GRID_COLS bits, cell state; bit r*GRID_COLS+c is the cell at row r, column c.
REQ-011 The block SHALL provide ports vid_vs_in, vid_hs_in and vid_de_in, each input, 1 bit: the upstream vsync pulse, hsync pulse and data enable.
REQ-012 The block SHALL provide ports vid_vs, vid_hs and vid_de, each output, 1 bit: the sync and enable inputs delayed to align with the colour output.
REQ-013 The block SHALL provide port vid_rgb, output, 24 bits, pixel colour as {R[7:0],G[7:0],B[7:0]}.

Function
REQ-014 The block SHALL hold a pixel position (px 0..CELL_W-1, cx 0..GRID_COLS) and a line position (py 0..CELL_H-1, cy 0..GRID_ROWS).
REQ-015 A cycle with vid_vs_in=1 SHALL clear px, cx, py and cy to 0 and clear a line_active flag; this applies even mid-frame.
REQ-016 On each cycle with vid_de_in=1, px SHALL increment; on the wrap from CELL_W-1 to 0, cx SHALL increment and then saturate at GRID_COLS.
REQ-017 On the first cycle with vid_de_in=1 after vid_de_in=0, line_active SHALL set.
REQ-018 A cycle with vid_hs_in=1 SHALL clear px and cx; if line_active=1, it SHALL also advance py (wrapping CELL_H-1 to 0 and incrementing cy, which saturates at GRID_ROWS) and then clear line_active.
REQ-019 Stage 1, one cycle after input, SHALL register the in_grid flag (cx<GRID_COLS and cy<GRID_ROWS), the cell bit grid_ram[cy*GRID_COLS+cx] (forced to 0 when not in_grid), the de flag, the gridline flag, and hs/vs.
REQ-020 Stage 2 SHALL register vid_rgb, where colour is BORDER_COLOR if not in_grid, else FG_COLOR for bit=1, else BG_COLOR.
REQ-021 vid_rgb SHALL be 24'h0 when the delayed de is 0.
REQ-022 Total latency SHALL be 2 cycles: vid_vs, vid_hs, vid_de and vid_rgb for input cycle n SHALL appear at cycle n+2.
REQ-023 The cell index arithmetic SHALL be sized to clog2(GRID_ROWS*GRID_COLS) bits, and the lookup SHALL never index out of range.
REQ-024 Changes to grid_ram SHALL take effect on the next pixel sampled; there SHALL be no frame buffering.
REQ-025 A line longer than GRID_COLS*CELL_W active pixels SHALL output BORDER_COLOR for the excess pixels.
REQ-026 Lines beyond GRID_ROWS*CELL_H SHALL output BORDER_COLOR until the next vid_vs_in.

Reset
REQ-027 While reset_n=0, vid_rgb SHALL be 0 and vid_vs, vid_hs and vid_de SHALL be 0.
REQ-028 While reset_n=0, all counters, line_active and pipeline registers SHALL be 0.
REQ-029 Reset asserted mid-line SHALL take effect immediately.
REQ-030 After reset release, output SHALL resume correctly from the next vid_vs_in; before that, it SHALL follow counters starting at 0.

Configuration
REQ-031 With GRID_SCANOUT_GRIDLINES_EN defined, in-grid pixels with px=0 or py=0 SHALL output the fixed colour 24'h404040 regardless of cell bit.
REQ-032 With GRID_SCANOUT_GRIDLINES_EN undefined, no gridline logic SHALL exist, and colour SHALL depend only on in_grid and the cell bit.

Verification
REQ-033 Reset: hold reset_n=0 while driving de=1 -> all outputs 0; release, pulse vs, then drive 320 de cycles -> first vid_de=1 appears 2 cycles after the first de_in.
REQ-034 Chessboard: set grid_ram bit = (r+c)%2 and run a full 320x240 frame -> pixel (0,0) is 000000, pixel (8,0) is FFFFFF, pixel (8,8) is 000000, pixel (319,239) is 000000.
REQ-035 Overscan: drive a 330-pixel line and 250 lines -> pixels x=320..329 and lines y=240..249 are 202020.
REQ-036 Mid-frame vs: pulse vs_in at line 100 -> the next line renders grid row 0.
REQ-037 Live update: set bit 41 while line 8 is active -> pixels x=8..15 on line 8 switch to FFFFFF from the next sampled pixel.
REQ-038 GRID_SCANOUT_GRIDLINES_EN defined with all cells 1 -> pixels x=0,8,16 and all pixels of line 0 are 404040; pixel (1,1) is FFFFFF.
